// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product, one partial step per clock.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses RUN and completes in a single cycle.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH:0]   a;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             q1_next;
  logic             zero_skip;
  logic             last_step;

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_skip = (multiplicand == '0) || (multiplier == '0);
`else
  assign zero_skip = 1'b0;
`endif

  assign last_step = (count == CW'(1));

  // One Booth step: add/subtract M by the bit pair, then arithmetic shift of {A,Q,q_1}.
  always_comb begin
    sum = a;
    case ({q[0], q_1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_next  = {sum[WIDTH], sum[WIDTH:1]};
    q_next  = {sum[0], q[WIDTH-1:1]};
    q1_next = q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = zero_skip ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {multiplicand[WIDTH-1], multiplicand};
            q     <= multiplier;
            a     <= '0;
            q_1   <= 1'b0;
            count <= CW'(WIDTH);
            if (zero_skip) begin
              product <= '0;
            end
          end
        end
        RUN: begin
          a     <= a_next;
          q     <= q_next;
          q_1   <= q1_next;
          count <= count - CW'(1);
          // The final step's result goes straight to product as DONE is entered.
          if (last_step) begin
            product <= {a_next[WIDTH-1:0], q_next};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq (WIDTH=8): expected products queued at start, compared on each done.
module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [1:0]     dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [2*W-1:0] exp_q[$];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .product(product),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pops one expected product.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [2*W-1:0] model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    logic signed [2*W-1:0] r;
    r = a * b;
    return r;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
    if (a == '0 || b == '0) return 1;
`endif
    return W + 1;
  endfunction

  // Called at posedge+1. extra_at > 0 pulses a second start during the operation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int extra_at);
    logic [2*W-1:0] prev;
    int n;
    int lat;
    lat = exp_latency(a, b);
    prev = product;
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = W'($urandom_range(0, 255));
    multiplier = W'($urandom_range(0, 255));
    n = 1;
    while (done !== 1'b1 && n < 30) begin
      check("busy_run", 32'(busy), 32'd1);
      check("product_stable", 32'(product), 32'(prev));
      if (extra_at > 0 && n == extra_at) begin
        start = 1'b1;
        multiplicand = 8'h11;
        multiplier = 8'h22;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'(lat));
    check("busy_done", 32'(busy), 32'd1);
    check("state_done", 32'(dbg_state), 32'd2);
    @(posedge clk); #1;
    check("busy_idle", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic wait_done(output int c);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_done_timeout", 32'(done), 32'd1);
    c = cyc;
  endtask

  initial begin
    int d1;
    int d2;
    // Reset state
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", 32'(done), 32'd0);

    // Basic products
    run_op(8'd3, 8'd5, 0);
    check("hold_after_done", 32'(product), 32'h000F);
    run_op(8'hF9, 8'd6, 0);
    run_op(8'h80, 8'h80, 0);
    run_op(8'd127, 8'h80, 0);
    run_op(8'd1, 8'hFF, 0);

    // Second start during RUN is ignored
    run_op(8'd7, 8'd9, 4);
    repeat (12) @(posedge clk);
    #1;
    check("no_extra_done_q", 32'(exp_q.size()), 32'd0);

    // Start held high: back-to-back operations every 10 cycles
    start = 1'b1;
    multiplicand = 8'd4;
    multiplier = 8'd9;
    exp_q.push_back(model(8'd4, 8'd9));
    exp_q.push_back(model(8'hFB, 8'd11));
    @(posedge clk); #1;
    multiplicand = 8'hFB;
    multiplier = 8'd11;
    wait_done(d1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_second_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    wait_done(d2);
    check("b2b_spacing", 32'(d2 - d1), 32'd10);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation aborts with no done
    start = 1'b1;
    multiplicand = 8'd9;
    multiplier = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done_q", 32'(exp_q.size()), 32'd0);
    run_op(8'd2, 8'hFD, 0);

    // Zero operands
    run_op(8'd0, 8'd55, 0);
    run_op(8'd55, 8'd0, 0);

    // A few random operand pairs
    for (int i = 0; i < 4; i++) begin
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 0);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (signed two's complement, minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiplication, sampled only in IDLE.
REQ-005 The block SHALL have port multiplicand, input, WIDTH bits: signed operand M, captured when start is accepted.
REQ-006 The block SHALL have port multiplier, input, WIDTH bits: signed operand Q, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while the operation is in progress (RUN or DONE).
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid product.
REQ-009 The block SHALL have port product, output, 2*WIDTH bits: signed result M*Q, registered.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE, held in a registered state variable.
REQ-011 In IDLE with start=1, on the next edge the block SHALL capture M and Q, clear accumulator A (WIDTH+1 bits, sign-extended arithmetic) and bit q_1, load count=WIDTH, and go to RUN.
REQ-012 Each RUN cycle SHALL examine {Q[0],q_1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> no change; then arithmetic-shift {A,Q,q_1} right by one and decrement count.
REQ-013 RUN SHALL last exactly WIDTH cycles; the block SHALL leave RUN for DONE when count reaches 0.
REQ-014 On entry to DONE the block SHALL load product with the low 2*WIDTH bits of {A,Q}; done=1 for exactly that one cycle; the next state is IDLE.
REQ-015 Latency SHALL be WIDTH+1 cycles, counted from the edge sampling start to the first cycle in which done=1 is visible.
REQ-016 product SHALL hold its value until the next DONE entry and SHALL NOT change during RUN.
REQ-017 start SHALL be ignored in RUN and DONE; no queuing; a start held high through DONE is accepted in the following IDLE cycle.
REQ-018 The operand pair -2^(WIDTH-1) * -2^(WIDTH-1) SHALL produce the correct positive result (A is WIDTH+1 bits to prevent overflow on subtraction).
REQ-019 busy SHALL be 1 exactly when state is RUN or DONE.
REQ-020 Operand inputs SHALL be ignored outside the start-accept edge.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, product=0, A=0, Q=0, q_1=0, count=0.
REQ-022 A reset asserted mid-operation SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-023 Reset deassertion SHALL take effect at a clock edge with no spurious done.

Configuration
REQ-024 With macro BOOTH_ZERO_SKIP_EN defined, an accepted start with M==0 or Q==0 SHALL go IDLE->DONE directly, with product=0 and done one cycle after acceptance (latency 1).
REQ-025 Without BOOTH_ZERO_SKIP_EN, zero operands SHALL follow the normal RUN path with latency WIDTH+1 and a zero result.

Verification (WIDTH=8)
REQ-026 start with M=3, Q=5 -> busy high for 9 cycles; done pulse at cycle 9; product=0x000F, stable until the next done.
REQ-027 M=-7 (0xF9), Q=6 -> product=0xFFD6 (-42); M=-128, Q=-128 -> product=0x4000; M=127, Q=-128 -> product=0xC080.
REQ-028 Second start pulse at cycle 4 of an operation -> ignored; one done only; product from the first operands; start held continuously -> back-to-back operations, one every 10 cycles.
REQ-029 rst_n low at cycle 5 of RUN -> busy=0, done=0, product=0 immediately; no done follows; next start M=2, Q=-3 -> product=0xFFFA.
REQ-030 M=0, Q=55 -> with BOOTH_ZERO_SKIP_EN, done at cycle 1 with product=0; without it, done at cycle 9 with product=0.
